// File: rtl/lzw_dict_ctrl.sv
// LZW dictionary controller: hashed (prefix,char) lookup with linear probing
// into an external single-port RAM, inserting a new code on a miss, plus a
// full-RAM wipe on reset or on request.
module lzw_dict_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_PROBE  = 8,
    parameter int FIRST_CODE = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [11:0]           req_prefix,
    input  logic [7:0]            req_char,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic                  rsp_inserted,
    output logic [11:0]           rsp_code,
    output logic                  dict_full,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_valid
);

    localparam int          PW        = $clog2(MAX_PROBE + 1);
    localparam logic [12:0] FULL_CODE = 13'd4096;
    localparam logic [12:0] FIRST     = 13'(FIRST_CODE);

    typedef enum logic [2:0] {CLEAR, IDLE, RD, WT, WR, RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [11:0]           r_prefix;
    logic [7:0]            r_char;
    logic [PW-1:0]         r_probe;
    logic [12:0]           r_next_code;
    logic                  r_rsp_hit;
    logic                  r_rsp_ins;
    logic [11:0]           r_rsp_code;

    logic [ADDR_WIDTH-1:0] w_home;
    logic                  w_used;
    logic                  w_match;
    logic                  w_hit;
    logic                  w_more;
    logic                  w_cs;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_entry;
    logic                  w_unused;

    assign w_home    = ADDR_WIDTH'(req_prefix ^ {req_char, 4'b0000});
    assign w_used    = ram_rdata[63];
    assign w_match   = (ram_rdata[19:8] == r_prefix) && (ram_rdata[7:0] == r_char);
    assign w_hit     = w_used && w_match;
    assign w_more    = (r_probe < PW'(MAX_PROBE - 1));
    assign w_unused  = ^{ram_rdata[62:44], ram_rdata[31:20]};
    assign dict_full = (r_next_code == FULL_CODE);

    // RAM strobes are held off while reset is applied so a held reset never writes
    assign ram_cs       = w_cs & ~rst;
    assign ram_we       = w_we & ~rst;
    assign ram_addr     = r_addr;
    assign rsp_hit      = r_rsp_hit;
    assign rsp_inserted = r_rsp_ins;
    assign rsp_code     = r_rsp_code;

    // Assemble the dictionary entry for the pending insert
    always_comb begin
        w_entry        = '0;
        w_entry[63]    = 1'b1;
        w_entry[43:32] = r_next_code[11:0];
        w_entry[19:8]  = r_prefix;
        w_entry[7:0]   = r_char;
    end

    // State register; reset always restarts the wipe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and RAM/handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cs        = 1'b0;
        w_we        = 1'b0;
        ram_wdata   = '0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            CLEAR: begin
                w_cs = 1'b1;
                w_we = 1'b1;
                if (&r_addr) w_state_nxt = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (clear)          w_state_nxt = CLEAR;
                else if (req_valid) w_state_nxt = RD;
            end
            RD: begin
                w_cs        = 1'b1;
                w_state_nxt = WT;
            end
            WT: begin
                if (ram_valid) begin
                    if (w_hit)                     w_state_nxt = RESP;
                    else if (!w_used && !dict_full) w_state_nxt = WR;
                    else if (w_used && w_more)      w_state_nxt = RD;
                    else                            w_state_nxt = RESP;
                end
            end
            WR: begin
                w_cs        = 1'b1;
                w_we        = 1'b1;
                ram_wdata   = w_entry;
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // Datapath: wipe/probe address, request latch, code counter, response fields
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_prefix    <= '0;
            r_char      <= '0;
            r_probe     <= '0;
            r_next_code <= FIRST;
            r_rsp_hit   <= 1'b0;
            r_rsp_ins   <= 1'b0;
            r_rsp_code  <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_addr      <= r_addr + ADDR_WIDTH'(1);
                    r_next_code <= FIRST;
                end
                IDLE: begin
                    if (clear) begin
                        r_addr      <= '0;
                        r_next_code <= FIRST;
                    end else if (req_valid) begin
                        r_prefix   <= req_prefix;
                        r_char     <= req_char;
                        r_addr     <= w_home;
                        r_probe    <= '0;
                        r_rsp_hit  <= 1'b0;
                        r_rsp_ins  <= 1'b0;
                        r_rsp_code <= '0;
                    end
                end
                WT: begin
                    if (ram_valid) begin
                        if (w_hit) begin
                            r_rsp_hit  <= 1'b1;
                            r_rsp_code <= ram_rdata[43:32];
                        end else if (w_used && w_more) begin
                            r_probe <= r_probe + PW'(1);
                            r_addr  <= r_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                WR: begin
                    r_rsp_ins   <= 1'b1;
                    r_rsp_code  <= r_next_code[11:0];
                    r_next_code <= r_next_code + 13'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// Directed bench for lzw_dict_ctrl with a behavioural single-port RAM.
module tb_lzw_dict_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_prefix;
    logic [7:0]  req_char;
    logic        rsp_valid;
    logic        rsp_hit;
    logic        rsp_inserted;
    logic [11:0] rsp_code;
    logic        dict_full;
    logic [11:0] ram_addr;
    logic [63:0] ram_wdata;
    logic        ram_cs;
    logic        ram_we;
    logic [63:0] ram_rdata;
    logic        ram_valid;

    logic [63:0] mem [0:4095];

    int          total = 0;
    int          bad   = 0;
    logic        g_hit;
    logic        g_ins;
    logic [11:0] g_code;
    int          g_lat;

    lzw_dict_ctrl #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(64),
        .MAX_PROBE (8),
        .FIRST_CODE(256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_prefix  (req_prefix),
        .req_char    (req_char),
        .rsp_valid   (rsp_valid),
        .rsp_hit     (rsp_hit),
        .rsp_inserted(rsp_inserted),
        .rsp_code    (rsp_code),
        .dict_full   (dict_full),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata),
        .ram_valid   (ram_valid)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data and valid appear the cycle after a read strobe
    always @(posedge clk) begin
        ram_valid <= ram_cs && !ram_we;
        if (ram_cs && !ram_we) ram_rdata <= mem[ram_addr];
        if (ram_cs && ram_we)  mem[ram_addr] <= ram_wdata;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Follows a wipe from its first cycle until req_ready rises
    task automatic clear_count(input string tag);
        int cyc = 0;
        int wr = 0;
        int seq_bad = 0;
        int rv = 0;
        int exp_addr = 0;
        #1;
        while (!req_ready && cyc < 5000) begin
            if (ram_cs && ram_we) begin
                if (int'(ram_addr) != exp_addr || ram_wdata !== 64'h0) seq_bad++;
                exp_addr++;
                wr++;
            end
            if (ram_cs && !ram_we) seq_bad++;
            if (rsp_valid) rv++;
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_cycles"}, cyc, 4096);
        chk({tag, "_writes"}, wr, 4096);
        chk({tag, "_order"}, seq_bad, 0);
        chk({tag, "_no_rsp"}, rv, 0);
        chk({tag, "_ready"}, req_ready, 1'b1);
        chk({tag, "_full"}, dict_full, 1'b0);
    endtask

    // One request; latency counts negedges after the accept edge
    task automatic do_req(input logic [11:0] p, input logic [7:0] c);
        int n = 0;
        g_hit  = 1'b0;
        g_ins  = 1'b0;
        g_code = '0;
        g_lat  = 999;
        while (!req_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) return;
        req_valid  = 1'b1;
        req_prefix = p;
        req_char   = c;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid) begin
            g_hit  = rsp_hit;
            g_ins  = rsp_inserted;
            g_code = rsp_code;
            g_lat  = n;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int bulk_bad;
        rst        = 1'b1;
        clear      = 1'b0;
        req_valid  = 1'b0;
        req_prefix = '0;
        req_char   = '0;
        repeat (3) @(negedge clk);

        chk("rst_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cs", ram_cs, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_code", rsp_code, 12'h000);
        chk("rst_full", dict_full, 1'b0);

        rst = 1'b0;
        clear_count("init");
        chk("idle_cs", ram_cs, 1'b0);
        chk("idle_we", ram_we, 1'b0);

        // 0xFFF home, then a second pair with the same home wraps to 0x000
        do_req(12'hFFF, 8'h00);
        chk("wrap1_ins", g_ins, 1'b1);
        chk("wrap1_code", g_code, 12'h100);
        chk("wrap1_lat", g_lat, 4);
        chk("wrap1_mem", mem[12'hFFF], 64'h8000_0100_000F_FF00);
        do_req(12'h00F, 8'hFF);
        chk("wrap2_ins", g_ins, 1'b1);
        chk("wrap2_code", g_code, 12'h101);
        chk("wrap2_lat", g_lat, 6);
        chk("wrap2_mem", mem[12'h000], 64'h8000_0101_0000_0FFF);
        do_req(12'h00F, 8'hFF);
        chk("wrap2_hit", g_hit, 1'b1);
        chk("wrap2_hit_code", g_code, 12'h101);
        chk("wrap2_hit_lat", g_lat, 5);

        // First-probe insert and first-probe hit
        do_req(12'h041, 8'h41);
        chk("a_ins", g_ins, 1'b1);
        chk("a_hit", g_hit, 1'b0);
        chk("a_code", g_code, 12'h102);
        chk("a_lat", g_lat, 4);
        chk("a_mem", mem[12'h451], 64'h8000_0102_0000_4141);
        do_req(12'h041, 8'h41);
        chk("a2_hit", g_hit, 1'b1);
        chk("a2_ins", g_ins, 1'b0);
        chk("a2_code", g_code, 12'h102);
        chk("a2_lat", g_lat, 3);

        // Collision at home 0x123 lands in 0x124
        do_req(12'h123, 8'h00);
        chk("col1_code", g_code, 12'h103);
        do_req(12'h133, 8'h01);
        chk("col2_ins", g_ins, 1'b1);
        chk("col2_code", g_code, 12'h104);
        chk("col2_lat", g_lat, 6);
        chk("col2_mem", mem[12'h124], 64'h8000_0104_0001_3301);
        do_req(12'h133, 8'h01);
        chk("col2_hit", g_hit, 1'b1);
        chk("col2_hit_code", g_code, 12'h104);
        chk("col2_hit_lat", g_lat, 5);

        // Eight pairs sharing home 0x300 fill every probe slot
        for (int c = 0; c < 8; c++) begin
            do_req(12'h300 ^ 12'(c << 4), 8'(c));
            chk($sformatf("chain%0d_code", c), g_code, 12'(12'h105 + c));
            chk($sformatf("chain%0d_lat", c), g_lat, 4 + 2 * c);
        end
        chk("chain7_mem", mem[12'h307], 64'h8000_010C_0003_7007);
        do_req(12'h380, 8'h08);
        chk("probe_exh_hit", g_hit, 1'b0);
        chk("probe_exh_ins", g_ins, 1'b0);
        chk("probe_exh_code", g_code, 12'h000);
        chk("probe_exh_lat", g_lat, 17);
        chk("probe_exh_mem", mem[12'h308], 64'h0);
        do_req(12'h370, 8'h07);
        chk("chain7_hit", g_hit, 1'b1);
        chk("chain7_hit_code", g_code, 12'h10C);
        chk("chain7_hit_lat", g_lat, 17);

        // clear wins over a simultaneous request
        wait_ready();
        clear      = 1'b1;
        req_valid  = 1'b1;
        req_prefix = 12'h555;
        req_char   = 8'h00;
        @(negedge clk);
        clear     = 1'b0;
        req_valid = 1'b0;
        chk("clr_ready_low", req_ready, 1'b0);
        clear_count("clr");

        // Fill to full with distinct homes 0..3839
        bulk_bad = 0;
        for (int i = 0; i < 3839; i++) begin
            do_req(12'(i), 8'h00);
            if (g_ins !== 1'b1 || g_code !== 12'(256 + i) || g_lat != 4) bulk_bad++;
        end
        chk("bulk_errors", bulk_bad, 0);
        chk("bulk_not_full", dict_full, 1'b0);
        do_req(12'hEFF, 8'h00);
        chk("bulk_last_code", g_code, 12'hFFF);
        chk("bulk_full", dict_full, 1'b1);
        do_req(12'hF00, 8'h00);
        chk("full_miss_hit", g_hit, 1'b0);
        chk("full_miss_ins", g_ins, 1'b0);
        chk("full_miss_code", g_code, 12'h000);
        chk("full_miss_lat", g_lat, 3);
        chk("full_miss_mem", mem[12'hF00], 64'h0);
        do_req(12'h005, 8'h00);
        chk("full_hit", g_hit, 1'b1);
        chk("full_hit_code", g_code, 12'h105);

        // Clear pulse resets the code counter and wipes the table
        wait_ready();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr2_full", dict_full, 1'b0);
        clear_count("clr2");
        do_req(12'h005, 8'h00);
        chk("clr2_ins", g_ins, 1'b1);
        chk("clr2_code", g_code, 12'h100);
        chk("clr2_lat", g_lat, 4);

        // Reset while waiting on read data
        wait_ready();
        req_valid  = 1'b1;
        req_prefix = 12'h777;
        req_char   = 8'h00;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("wtrst_rsp_valid", rsp_valid, 1'b0);
        chk("wtrst_cs", ram_cs, 1'b0);
        chk("wtrst_we", ram_we, 1'b0);
        chk("wtrst_ready", req_ready, 1'b0);
        chk("wtrst_rsp", {rsp_hit, rsp_inserted, rsp_code}, 14'h0);
        rst = 1'b0;
        clear_count("wtrst");
        do_req(12'h777, 8'h00);
        chk("wtrst_ins", g_ins, 1'b1);
        chk("wtrst_code", g_code, 12'h100);
        chk("wtrst_lat", g_lat, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
